// File: rtl/main_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// main_fsm : multicycle RISC-V control FSM (Moore), PCWrite gated by Zero
// Revision : 1.0
// ----------------------------------------------------------------------------
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state
);

  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic       pc_update, branch;
  logic       adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        state_d    = S_DECODE;
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          c_OP_LW, c_OP_SW: state_d = S_MEMADR;
          c_OP_R:           state_d = S_EXECUTER;
          c_OP_I:           state_d = S_EXECUTEI;
          c_OP_JAL:         state_d = S_JAL;
          c_OP_BEQ:         state_d = S_BEQ;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset shows FETCH decode on the selects but must not let any write enable through.
  assign PCWrite   = ~reset & (pc_update | (branch & Zero));
  assign IRWrite   = ~reset & ir_write;
  assign RegWrite  = ~reset & reg_write;
  assign MemWrite  = ~reset & mem_write;
  assign AdrSrc    = adr_src;
  assign ResultSrc = result_src;
  assign ALUSrcA   = alu_src_a;
  assign ALUSrcB   = alu_src_b;
  assign ALUOp     = alu_op;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_main_fsm.sv
`default_nettype none
// tb_main_fsm : randomized opcode streams against an instruction-path model,
// plus directed instruction traces and an asynchronous reset case.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int exp_state = 0;
  int trace[$];
  logic pcw_seen [0:15];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

  // Instruction path: the sequence of states visited, FETCH first.
  function automatic void build_path(input logic [6:0] o, output int p[$]);
    p = {0, 1};
    case (o)
      LW: p = {0, 1, 2, 3, 4};
      SW: p = {0, 1, 2, 5};
      RT: p = {0, 1, 6, 7};
      IT: p = {0, 1, 8, 7};
      JL: p = {0, 1, 9, 7};
      BQ: p = {0, 1, 10};
      default: p = {0, 1};
    endcase
  endfunction

  // Output table per state; packed {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}.
  function automatic logic [12:0] exp_out(input int s, input logic z, input logic rst);
    logic pcu, br, adr, mw, irw, rw;
    logic [1:0] rs, a, b, alu;
    {pcu, br, adr, mw, irw, rw, rs, a, b, alu} = '0;
    case (s)
      0:  begin irw = 1; pcu = 1; b = 2'b10; rs = 2'b10; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1;
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2'b10; alu = 2'b10; end
      7:  rw = 1;
      8:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      9:  begin a = 2'b01; b = 2'b10; pcu = 1; end
      10: begin a = 2'b10; alu = 2'b01; br = 1; end
      default: ;
    endcase
    if (rst) {pcu, br, mw, irw, rw} = '0;
    return {pcu | (br & z), adr, mw, irw, rw, rs, a, b, alu};
  endfunction

  // Single compare process: every negedge while checking is enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [12:0] act, exp_v;
      act   = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
      exp_v = exp_out(exp_state, Zero, reset);
      checks++;
      if (state !== exp_state[3:0]) begin
        errors++;
        $display("FAIL state t=%0t: got %0d expected %0d", $time, state, exp_state);
      end
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t state=%0d: got %013b expected %013b", $time, exp_state, act, exp_v);
      end
      if (!reset) begin
        trace.push_back(int'(state));
        pcw_seen[state] = PCWrite;
      end
    end
  end

  // zmode: 0 random Zero, 1 force 0, 2 force 1. abort_at >= 0 asserts reset mid-cycle at that path index.
  task automatic run_instr(input logic [6:0] opc, input int zmode, input bit scramble, input int abort_at);
    int p[$];
    build_path(opc, p);
    trace.delete();
    for (int k = 0; k < p.size(); k++) begin
      exp_state = p[k];
      Zero = (zmode == 0) ? 1'($urandom) : (zmode == 2);
      if (k == 1 || k == 2) op = opc;
      else if (scramble) op = 7'($urandom);
      else op = opc;
      if (k == abort_at) begin
        #1;
        reset = 1'b1;
        exp_state = 0;
        #1;
        checks++;
        if (state !== 4'd0 || RegWrite !== 1'b0 || PCWrite !== 1'b0) begin
          errors++;
          $display("FAIL async_reset: got state=%0d RegWrite=%b PCWrite=%b expected 0 0 0",
                   state, RegWrite, PCWrite);
        end
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b0;
        return;
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic check_trace(input string name, input int e[$]);
    logic [31:0] ap = '0, ep = '0;
    foreach (trace[i]) ap = (ap << 4) | 32'(trace[i]);
    foreach (e[i])     ep = (ep << 4) | 32'(e[i]);
    checks++;
    if (ap !== ep || trace.size() != e.size()) begin
      errors++;
      $display("FAIL trace_%s: got %0h (len %0d) expected %0h (len %0d)",
               name, ap, trace.size(), ep, e.size());
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops [6];
    ops = '{LW, SW, RT, IT, JL, BQ};
    reset = 1'b1; op = 7'd0; Zero = 1'b0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    exp_state = 0;
    @(posedge clk); #2;
    reset = 1'b0;

    run_instr(LW, 0, 1'b0, -1); check_trace("lw", {0, 1, 2, 3, 4});
    run_instr(SW, 0, 1'b0, -1); check_trace("sw", {0, 1, 2, 5});
    run_instr(RT, 0, 1'b0, -1); check_trace("rtype", {0, 1, 6, 7});
    run_instr(IT, 0, 1'b0, -1); check_trace("itype", {0, 1, 8, 7});
    run_instr(BQ, 2, 1'b0, -1); check_trace("beq_z1", {0, 1, 10});
    check_bit("beq_z1_pcwrite", pcw_seen[10], 1'b1);
    run_instr(BQ, 1, 1'b0, -1); check_trace("beq_z0", {0, 1, 10});
    check_bit("beq_z0_pcwrite", pcw_seen[10], 1'b0);
    run_instr(7'b1111111, 0, 1'b0, -1); check_trace("illegal", {0, 1});
    run_instr(JL, 0, 1'b0, -1); check_trace("jal", {0, 1, 9, 7});
    check_bit("jal_pcwrite", pcw_seen[9], 1'b1);
    run_instr(LW, 0, 1'b0, 4);
    run_instr(SW, 0, 1'b1, -1); check_trace("sw_after_reset", {0, 1, 2, 5});

    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      int p[$];
      int ab;
      o = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
      build_path(o, p);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, p.size() - 1) : -1;
      run_instr(o, 0, 1'b1, ab);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset (clk, reset).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces state to FETCH.
REQ-005 op  input  7  opcode field from the instruction register, stable from DECODE until return to FETCH.
REQ-006 Zero  input  1  ALU zero flag, used in BEQ.
REQ-007 PCWrite  output  1  PC register enable.
REQ-008 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 MemWrite  output  1  data memory write enable.
REQ-010 IRWrite  output  1  instruction register enable.
REQ-011 RegWrite  output  1  register file write enable.
REQ-012 ResultSrc  output  2  result mux select.
REQ-013 ALUSrcA  output  2  ALU A-operand select.
REQ-014 ALUSrcB  output  2  ALU B-operand select.
REQ-015 ALUOp  output  2  class code feeding the ALU decoder: 00 = add, 01 = subtract, 10 = decode funct3/funct7.
REQ-016 state  output  4  current state encoding, for debug and bench observation.

Function
REQ-017 The block SHALL be a Moore FSM, with all outputs except PCWrite decoded from state only.
REQ-018 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10.
REQ-019 Encodings 11-15 SHALL transition to FETCH on the next edge and drive all enables to 0.
REQ-020 Outputs per state SHALL be as follows; any field not listed is 0:
- FETCH: IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
REQ-021 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinationally. PCUpdate and Branch are internal signals.
REQ-022 Transitions SHALL be:
- FETCH -> DECODE.
- DECODE on op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; any other value -> FETCH.
- MEMADR: op 0000011 -> MEMREAD, otherwise -> MEMWRITE.
- MEMREAD -> MEMWB -> FETCH.
- MEMWRITE -> FETCH.
- EXECUTER, EXECUTEI and JAL -> ALUWB.
- ALUWB -> FETCH.
- BEQ -> FETCH, regardless of Zero.
REQ-023 Instruction latency in cycles, FETCH through the last state, SHALL be: lw 5; sw, R-type, I-type and jal 4; beq 3; illegal opcode 2.
REQ-024 op SHALL be sampled only in DECODE and MEMADR. Changes to op in any other state SHALL have no effect.

Reset
REQ-025 Asserting reset SHALL force state to FETCH immediately, with no clock edge required.
REQ-026 While reset is high, PCWrite, IRWrite, RegWrite and MemWrite SHALL be 0. All other outputs SHALL take their FETCH values.
REQ-027 The first rising edge after reset deasserts SHALL be the FETCH cycle, and the FSM SHALL then advance to DECODE.
REQ-028 Reset asserted in any state mid-instruction SHALL abandon that instruction, and no further write enable SHALL assert until FETCH is re-entered after release.

Verification
REQ-029 lw: hold op=0000011 after reset. state SHALL run 0,1,2,3,4,0. RegWrite=1 only in state 4, with ResultSrc=01.
REQ-030 sw: op=0100011. state SHALL run 0,1,2,5,0. MemWrite=1 and AdrSrc=1 only in state 5. RegWrite SHALL never be 1.
REQ-031 R-type then I-type: op=0110011 SHALL run 0,1,6,7,0 with ALUOp=10 in state 6. op=0010011 SHALL run 0,1,8,7,0 with ALUSrcB=01 in state 8.
REQ-032 beq: op=1100011 with Zero=1 in state 10 SHALL give PCWrite=1 and ALUOp=01. With Zero=0, PCWrite SHALL be 0. Both cases SHALL return to state 0 next.
REQ-033 Illegal opcode and jal: op=1111111 SHALL run 0,1,0. op=1101111 SHALL run 0,1,9,7,0 with PCWrite=1 in state 9.
REQ-034 Async reset: assert reset mid-cycle in state 4. state SHALL be 0 before the next edge, and RegWrite and PCWrite SHALL be 0 while reset is high.
